// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with 16x oversampling and a one-entry valid/ready holding register.
module uart_byte_rx #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);
    localparam int DIV_RAW = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int DW      = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    state_t state, next;

    logic          rx_m, rx_s;
    logic [DW-1:0] div_cnt;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          tick, sample, deliver, ferr;

    assign tick   = (state != IDLE) && (div_cnt == DW'(DIV - 1));
    assign sample = (state == DATA) && tick && (tick_cnt == 4'd15);
    assign o_busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            state <= IDLE;
        end else begin
            rx_m  <= i_rx;
            rx_s  <= rx_m;
            state <= next;
        end
    end

    always_comb begin
        next    = state;
        deliver = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE:      next = rx_s ? IDLE : START;
            START:     if (tick && tick_cnt == 4'd7) next = rx_s ? IDLE : DATA;
            DATA:      if (sample && bit_cnt == 3'd7) next = STOP;
            STOP: if (tick && tick_cnt == 4'd15) begin
                deliver = rx_s;
                ferr    = !rx_s;
                next    = rx_s ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: next = rx_s ? IDLE : WAIT_IDLE;
            default:   next = IDLE;
        endcase
    end

    // Counters are held at zero in IDLE so every frame starts phase-aligned to its start edge.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) tick_cnt <= (state == START && tick_cnt == 4'd7) ? 4'd0 : tick_cnt + 4'd1;
            if (sample) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) shift <= '0;
        else if (sample) shift <= {rx_s, shift[7:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= ferr;
            o_overrun   <= deliver && o_valid && !i_ready;
            if (deliver && (!o_valid || i_ready)) begin
                o_data  <= shift;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed frames with a scoreboard of expected bytes popped by a handshake monitor.
module tb_uart_byte_rx;
    logic       clk = 1'b0;
    logic       rst, i_rx, i_ready;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_overrun, o_busy;

    int checks = 0, fails = 0;
    int vcnt = 0, fcnt = 0, ocnt = 0;
    int v0, f0, o0;
    logic [7:0] q[$];

    uart_byte_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        i_rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) drive(b[i], 16);
        drive(stop, 16);
    endtask

    task automatic snap();
        v0 = vcnt;
        f0 = fcnt;
        o0 = ocnt;
    endtask

    // Monitor: counts flag/valid cycles and checks every accepted byte against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (o_valid) vcnt++;
        if (o_frame_err) fcnt++;
        if (o_overrun) ocnt++;
        if (o_valid && i_ready) begin
            checks++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_byte: got %02h expected none", o_data);
            end else begin
                logic [7:0] e;
                e = q.pop_front();
                if (o_data !== e) begin
                    fails++;
                    $display("FAIL rx_byte: got %02h expected %02h", o_data, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        i_rx = 1'b1;
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ferr", o_frame_err, 0);
        chk("rst_ovr", o_overrun, 0);
        rst = 1'b0;
        drive(1'b1, 32);

        // 1: plain byte, consumer ready
        snap();
        q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        drive(1'b1, 4);
        chk("t1_valid_cycles", vcnt - v0, 1);
        chk("t1_ferr", fcnt - f0, 0);
        chk("t1_busy", o_busy, 0);
        chk("t1_q_empty", q.size(), 0);

        // 2: false start
        snap();
        drive(1'b0, 5);
        drive(1'b1, 10);
        chk("t2_busy", o_busy, 0);
        chk("t2_valid", vcnt - v0, 0);
        chk("t2_ferr", fcnt - f0, 0);

        // 3: framing error, stuck-low line, then recovery
        snap();
        send(8'h3C, 1'b0);
        drive(1'b0, 40 * 16);
        drive(1'b1, 32);
        chk("t3_ferr_pulse", fcnt - f0, 1);
        chk("t3_no_valid", vcnt - v0, 0);
        q.push_back(8'h11);
        send(8'h11, 1'b1);
        drive(1'b1, 4);
        chk("t3_ferr_total", fcnt - f0, 1);
        chk("t3_valid", vcnt - v0, 1);
        chk("t3_q_empty", q.size(), 0);

        // 4: overrun while consumer stalled
        snap();
        i_ready = 1'b0;
        q.push_back(8'h01);
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        drive(1'b1, 4);
        chk("t4_ovr", ocnt - o0, 1);
        chk("t4_valid_held", o_valid, 1);
        chk("t4_data_kept", o_data, 8'h01);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk("t4_valid_drop", o_valid, 0);
        chk("t4_q_empty", q.size(), 0);
        i_ready = 1'b1;
        drive(1'b1, 16);

        // 5: reset mid-frame during data bit 3
        drive(1'b0, 16);
        drive(1'b1, 48);
        drive(1'b1, 8);
        chk("t5_busy_pre", o_busy, 1);
        snap();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_valid", o_valid, 0);
        chk("t5_busy", o_busy, 0);
        chk("t5_data", o_data, 0);
        chk("t5_ferr_now", o_frame_err, 0);
        chk("t5_ovr_now", o_overrun, 0);
        drive(1'b1, 7 + 4 * 16 + 16);
        drive(1'b1, 20 * 16);
        chk("t5_no_valid", vcnt - v0, 0);
        chk("t5_no_ferr", fcnt - f0, 0);
        chk("t5_no_ovr", ocnt - o0, 0);
        snap();
        q.push_back(8'h7E);
        send(8'h7E, 1'b1);
        drive(1'b1, 4);
        chk("t5_valid_7e", vcnt - v0, 1);

        // 6: back-to-back frames
        snap();
        q.push_back(8'h00);
        q.push_back(8'hFF);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        drive(1'b1, 4);
        chk("t6_valid", vcnt - v0, 2);
        chk("t6_ferr", fcnt - f0, 0);
        chk("t6_ovr", ocnt - o0, 0);
        chk("final_q_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
